// File: rtl/regfile_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default NUM_REGS / ADDR_W / DATA_W, BYTES_PER_REG.
package regfile_dump_pkg;

   localparam int NUM_REGS_DEF  = 32;
   localparam int ADDR_W_DEF    = 5;
   localparam int DATA_W_DEF    = 32;
   localparam int BYTES_PER_REG = DATA_W_DEF / 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SEND,
      ST_CKSUM,
      ST_DONE
   } state_t;

endpackage

// File: rtl/regfile_dump_reader_byte_serializer.sv
// Loads a DATA_W word and emits it MSB-first as bytes on a valid/ready port.
// Latency: first byte valid the cycle after load_i; one byte per accepted beat.
// Backpressure: tx_dat_o/tx_vld_o hold stable while tx_vld_o && !tx_rdy_i.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   load_i           parallel load (wins over a same-cycle acceptance)
//   load_dat_i       word to load
//   load_one_i       load only load_dat_i[7:0] as a single-byte burst
//   tx_dat_o/_vld_o  byte output, tx_rdy_i accepts
//   last_o           current byte is the final byte of the burst
module dump_byte_serializer #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_dat_i,
   input  logic              load_one_i,
   input  logic              tx_rdy_i,
   output logic [7:0]        tx_dat_o,
   output logic              tx_vld_o,
   output logic              last_o
);

   localparam int BPR   = DATA_W / 8;
   localparam int CNT_W = $clog2(BPR + 1);

   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              vld_q;

   assign tx_dat_o = shift_q[DATA_W-1 -: 8];
   assign tx_vld_o = vld_q;
   assign last_o   = (cnt_q == CNT_W'(BPR - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
      end else if (load_i) begin
         // A single-byte burst is placed in the top byte and the counter
         // is preset to the final index so it ends after one acceptance.
         if (load_one_i) begin
            shift_q <= DATA_W'(load_dat_i[7:0]) << (DATA_W - 8);
            cnt_q   <= CNT_W'(BPR - 1);
         end else begin
            shift_q <= load_dat_i;
            cnt_q   <= '0;
         end
         vld_q <= 1'b1;
      end else if (vld_q && tx_rdy_i) begin
         shift_q <= shift_q << 8;
         cnt_q   <= last_o ? '0 : cnt_q + 1'b1;
         vld_q   <= !last_o;
      end
   end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register-file address and streams each word out MSB-first as bytes.
// Latency: 1 LATCH cycle + DATA_W/8 byte beats per register; Done one cycle after last byte.
// Backpressure: tx_rdy_i low stalls the stream one cycle per low cycle; data held stable.
//
// Ports: clk_i, rst_i (sync, active-high), start_i, read_register_o -> regfile,
//        read_data_i <- regfile (combinational), tx_dat_o/tx_vld_o/tx_rdy_i byte
//        stream, busy_o, done_o.
// Option: define DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module regfile_dump_reader
   import regfile_dump_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] read_register_o,
   input  logic [DATA_W-1:0] read_data_i,
   output logic [7:0]        tx_dat_o,
   output logic              tx_vld_o,
   input  logic              tx_rdy_i,
   output logic              busy_o,
   output logic              done_o
);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              busy_q;
   logic              done_q;

   logic              ser_load;
   logic              ser_load_one;
   logic [DATA_W-1:0] ser_load_dat;
   logic              ser_last;
   logic              accept;
   logic              more_regs;

   assign accept          = tx_vld_o && tx_rdy_i;
   // Terminal test is against the configured register count, not the
   // address-space size, so a partially populated address range never wraps.
   assign more_regs       = (addr_q < ADDR_W'(NUM_REGS - 1));
   assign read_register_o = addr_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;

`ifdef DUMP_CHECKSUM_EN
   logic [7:0] csum_q;
   logic [7:0] csum_d;

   // Include the byte being accepted this cycle, so the final data byte is
   // folded in when the checksum is loaded on the same edge.
   assign csum_d = csum_q ^ tx_dat_o;

   always_comb begin
      ser_load     = 1'b0;
      ser_load_one = 1'b0;
      ser_load_dat = read_data_i;
      if (state_q == ST_LATCH) begin
         ser_load = 1'b1;
      end else if (state_q == ST_SEND && accept && ser_last && !more_regs) begin
         ser_load     = 1'b1;
         ser_load_one = 1'b1;
         ser_load_dat = DATA_W'(csum_d);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         csum_q <= '0;
      end else if (state_q == ST_IDLE && start_i) begin
         csum_q <= '0;
      end else if (state_q == ST_SEND && accept) begin
         csum_q <= csum_d;
      end
   end
`else
   assign ser_load     = (state_q == ST_LATCH);
   assign ser_load_one = 1'b0;
   assign ser_load_dat = read_data_i;
`endif

   dump_byte_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (ser_load),
      .load_dat_i (ser_load_dat),
      .load_one_i (ser_load_one),
      .tx_rdy_i   (tx_rdy_i),
      .tx_dat_o   (tx_dat_o),
      .tx_vld_o   (tx_vld_o),
      .last_o     (ser_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q <= ST_LATCH;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_LATCH: begin
               state_q <= ST_SEND;
            end
            ST_SEND: begin
               if (accept && ser_last) begin
                  if (more_regs) begin
                     addr_q  <= addr_q + 1'b1;
                     state_q <= ST_LATCH;
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     state_q <= ST_CKSUM;
`else
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
`endif
                  end
               end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CKSUM: begin
               if (accept) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               state_q <= ST_IDLE;
               addr_q  <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               addr_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: byte stream, timing, stalls,
// ignored re-start, and mid-dump reset against a modelled register file.
// Compile with DUMP_CHECKSUM_EN to expect the trailing checksum byte.
module tb_regfile_dump_reader;

`ifdef DUMP_CHECKSUM_EN
   localparam int NB       = 129;
   localparam int DONE_LAT = 162;
`else
   localparam int NB       = 128;
   localparam int DONE_LAT = 161;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rdy;
   logic [4:0]  ra;
   logic [31:0] rd;
   logic [7:0]  dat;
   logic        vld;
   logic        busy;
   logic        done;

   logic [31:0] regs [32];
   assign rd = regs[ra];

   regfile_dump_reader dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .read_register_o (ra),
      .read_data_i     (rd),
      .tx_dat_o        (dat),
      .tx_vld_o        (vld),
      .tx_rdy_i        (rdy),
      .busy_o          (busy),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] cap [$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         first_vld_cyc = -1;
   bit         stall_mode = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_dat = 8'h00;

   typedef struct {
      int         idx;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte n of the expected stream, derived from the modelled register file.
   function automatic logic [7:0] exp_byte(input int n);
      logic [31:0] w;
      logic [7:0]  x;
      if (n < 128) begin
         w = regs[n / 4];
         return w[31 - 8 * (n % 4) -: 8];
      end
      x = 8'h00;
      for (int i = 0; i < 128; i++) x = x ^ exp_byte(i);
      return x;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (vld && rdy) cap.push_back(dat);
         if (vld && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (stall_mode && prev_stall) begin
            chk("hold_vld", {31'd0, vld}, 32'd1);
            chk("hold_dat", {24'd0, dat}, {24'd0, prev_dat});
         end
         prev_stall = vld && !rdy;
         prev_dat   = dat;
      end
   end

   // Stall mode: every byte is refused once, then accepted.
   always @(posedge clk) begin
      #1;
      if (stall_mode) rdy = vld ? !rdy : 1'b1;
   end

   task automatic do_start(output int t0);
      @(posedge clk);
      #1;
      done_cnt      = 0;
      first_vld_cyc = -1;
      cap.delete();
      t0    = cyc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt == 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no Done within %0d cycles", budget);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_bytes(input int nbytes, input int budget);
      int n;
      n = 0;
      while (cap.size() < nbytes && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (cap.size() < nbytes) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: %0d bytes seen, wanted %0d", cap.size(), nbytes);
      end
   endtask

   task automatic check_stream(input string name);
      int bad;
      int first_bad;
      bad       = 0;
      first_bad = -1;
      chk({name, "_count"}, cap.size(), NB);
      for (int i = 0; i < NB && i < cap.size(); i++) begin
         if (cap[i] !== exp_byte(i)) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      if (bad != 0) $display("first bad byte index %0d in %s", first_bad, name);
      chk({name, "_bytes_bad"}, bad, 0);
   endtask

   task automatic check_table();
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].idx < cap.size())
            chk($sformatf("byte%0d", tbl[i].idx), {24'd0, cap[tbl[i].idx]}, {24'd0, tbl[i].exp});
         else
            chk($sformatf("byte%0d_missing", tbl[i].idx), cap.size(), tbl[i].idx + 1);
      end
   endtask

   initial begin
      int t0;

      for (int i = 0; i < 32; i++) regs[i] = i;
      regs[5]  = 32'hDEAD_BEEF;
      regs[10] = 32'hCAFE_BABE;

      tbl.push_back('{0,   8'h00});
      tbl.push_back('{3,   8'h00});
      tbl.push_back('{7,   8'h01});
      tbl.push_back('{11,  8'h02});
      tbl.push_back('{20,  8'hDE});
      tbl.push_back('{21,  8'hAD});
      tbl.push_back('{22,  8'hBE});
      tbl.push_back('{23,  8'hEF});
      tbl.push_back('{40,  8'hCA});
      tbl.push_back('{41,  8'hFE});
      tbl.push_back('{42,  8'hBA});
      tbl.push_back('{43,  8'hBE});
      tbl.push_back('{124, 8'h00});
      tbl.push_back('{127, 8'h1F});
`ifdef DUMP_CHECKSUM_EN
      tbl.push_back('{128, 8'h1D});
`endif

      // Reset, with Start asserted during reset: reset must win.
      rst   = 1'b1;
      start = 1'b1;
      rdy   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("rst_addr", {27'd0, ra}, 32'd0);
      chk("rst_dat", {24'd0, dat}, 32'd0);
      chk("rst_vld", {31'd0, vld}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Full-rate dump.
      do_start(t0);
      @(negedge clk);
      chk("busy_in_dump", {31'd0, busy}, 32'd1);
      wait_done(400);
      chk("first_vld_lat", first_vld_cyc - t0, 2);
      chk("done_lat", done_cyc - t0, DONE_LAT);
      chk("done_pulses", done_cnt, 1);
      check_stream("fast");
      check_table();
      @(negedge clk);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_addr", {27'd0, ra}, 32'd0);

      // Every byte stalled once: same stream, NB extra cycles.
      stall_mode = 1'b1;
      do_start(t0);
      wait_done(800);
      stall_mode = 1'b0;
      rdy        = 1'b1;
      chk("stall_done_lat", done_cyc - t0, DONE_LAT + NB);
      chk("stall_done_pulses", done_cnt, 1);
      check_stream("stall");

      // Start pulsed again mid-dump must be ignored.
      do_start(t0);
      wait_bytes(50, 400);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(400);
      repeat (20) @(posedge clk);
      chk("restart_done_pulses", done_cnt, 1);
      chk("restart_done_lat", done_cyc - t0, DONE_LAT);
      check_stream("restart");
      @(negedge clk);
      chk("restart_idle_busy", {31'd0, busy}, 32'd0);

      // Reset while register 10 is being sent.
      do_start(t0);
      wait_bytes(41, 400);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_addr", {27'd0, ra}, 32'd0);
      chk("mid_rst_dat", {24'd0, dat}, 32'd0);
      chk("mid_rst_vld", {31'd0, vld}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_stays_idle", {31'd0, busy}, 32'd0);

      // Fresh dump after reset starts from register 0.
      do_start(t0);
      wait_done(400);
      chk("fresh_done_pulses", done_cnt, 1);
      chk("fresh_done_lat", done_cyc - t0, DONE_LAT);
      check_stream("fresh");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
